// File: rtl/branch_history_table.sv
// Direct-mapped tagged table of 2-bit saturating counters for dynamic branch direction prediction.
// Define BHT_BYPASS_EN to forward a same-cycle update on the lookup index into hit_o/taken_o.
module branch_history_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        fallback_taken_i,
  output logic        taken_o,
  output logic        hit_o,
  input  logic        update_en_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = 2 + INDEX_WIDTH;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_WIDTH-1:0] r_tag [ENTRIES];
  logic [1:0]           r_ctr [ENTRIES];

  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_WIDTH-1:0]   w_lk_tag;
  logic [INDEX_WIDTH-1:0] w_up_idx;
  logic [TAG_WIDTH-1:0]   w_up_tag;
  logic                   w_up_hit;
  logic                   w_up_write;
  logic [1:0]             w_up_ctr;
  logic                   w_rd_valid;
  logic [TAG_WIDTH-1:0]   w_rd_tag;
  logic [1:0]             w_rd_ctr;
  logic                   w_unused;

  assign w_lk_idx   = pc_i[2 +: INDEX_WIDTH];
  assign w_lk_tag   = pc_i[TAG_LSB +: TAG_WIDTH];
  assign w_up_idx   = update_pc_i[2 +: INDEX_WIDTH];
  assign w_up_tag   = update_pc_i[TAG_LSB +: TAG_WIDTH];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_write = update_en_i && !flush_i;

  assign w_unused = ^{pc_i[1:0], pc_i[31:TAG_LSB+TAG_WIDTH],
                      update_pc_i[1:0], update_pc_i[31:TAG_LSB+TAG_WIDTH]};

  // Next counter value: saturating step on a hit, weak-state allocation on a miss.
  always_comb begin
    w_up_ctr = 2'b01;
    if (w_up_hit) begin
      if (update_taken_i) begin
        w_up_ctr = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
      end else begin
        w_up_ctr = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
      end
    end else begin
      w_up_ctr = update_taken_i ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (update_en_i) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Tags and counters are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (w_up_write) begin
      r_tag[w_up_idx] <= w_up_tag;
      r_ctr[w_up_idx] <= w_up_ctr;
    end
  end

  always_comb begin
    w_rd_valid = r_valid[w_lk_idx];
    w_rd_tag   = r_tag[w_lk_idx];
    w_rd_ctr   = r_ctr[w_lk_idx];
`ifdef BHT_BYPASS_EN
    if (w_up_write && (w_up_idx == w_lk_idx)) begin
      w_rd_valid = 1'b1;
      w_rd_tag   = w_up_tag;
      w_rd_ctr   = w_up_ctr;
    end
`endif
  end

  assign hit_o   = w_rd_valid && (w_rd_tag == w_lk_tag);
  assign taken_o = hit_o ? w_rd_ctr[1] : fallback_taken_i;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: table-driven per-cycle vectors with a scoreboard queue,
// plus hand-written reset sequences. Expectations follow the BHT_BYPASS_EN setting of the build.
module tb_branch_history_table;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] pc_i;
  logic        fallback_taken_i;
  logic        taken_o;
  logic        hit_o;
  logic        update_en_i;
  logic [31:0] update_pc_i;
  logic        update_taken_i;

`ifdef BHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  branch_history_table #(.INDEX_WIDTH(6), .TAG_WIDTH(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .pc_i             (pc_i),
    .fallback_taken_i (fallback_taken_i),
    .taken_o          (taken_o),
    .hit_o            (hit_o),
    .update_en_i      (update_en_i),
    .update_pc_i      (update_pc_i),
    .update_taken_i   (update_taken_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic        fb;
    logic        upd;
    logic [31:0] upc;
    logic        ut;
    logic        eh;
    logic        et;
  } vec_t;

  typedef struct {
    int   id;
    logic eh;
    logic et;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic fl, input logic [31:0] pc, input logic fb, input logic upd,
                     input logic [31:0] upc, input logic ut, input logic eh, input logic et);
    vec_t v;
    v.flush = fl; v.pc = pc; v.fb = fb; v.upd = upd; v.upc = upc; v.ut = ut; v.eh = eh; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ah, input logic at, input logic eh, input logic et);
    n_checks++;
    if (ah !== eh || at !== et) begin
      n_errors++;
      $display("FAIL %s: got hit=%b taken=%b, expected hit=%b taken=%b", name, ah, at, eh, et);
    end
  endtask

  initial begin
    exp_t e;
    // fl   pc         fb  upd upc        ut   exp_hit exp_taken
    add(0, 32'h400, 1, 0, 32'h0,   0, 0, 1);
    add(0, 32'h400, 0, 0, 32'h0,   0, 0, 0);
    add(0, 32'h400, 0, 1, 32'h400, 1, BYP, BYP);        // same-cycle allocate
    add(0, 32'h400, 0, 0, 32'h0,   0, 1, 1);            // ctr=10
    add(0, 32'h400, 0, 1, 32'h400, 1, 1, 1);            // ->11
    add(0, 32'h400, 0, 1, 32'h400, 1, 1, 1);            // stays 11
    add(0, 32'h400, 0, 1, 32'h400, 1, 1, 1);
    add(0, 32'h400, 0, 1, 32'h400, 0, 1, 1);            // 11->10
    add(0, 32'h400, 0, 0, 32'h0,   0, 1, 1);
    add(0, 32'h400, 0, 1, 32'h400, 0, 1, !BYP);         // 10->01
    add(0, 32'h400, 1, 0, 32'h0,   0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 32'h400, 0, 1, 32'h400, 0, 1, 0);
    add(0, 32'h400, 1, 0, 32'h0,   0, 1, 0);            // ctr=00, no wrap
    add(0, 32'h400, 1, 1, 32'h400, 1, 1, 0);            // 00->01
    add(0, 32'h400, 1, 0, 32'h0,   0, 1, 0);
    add(0, 32'h500, 1, 1, 32'h500, 0, BYP, !BYP);       // alias evicts 0x400
    add(0, 32'h400, 1, 0, 32'h0,   0, 0, 1);
    add(0, 32'h500, 1, 0, 32'h0,   0, 1, 0);
    add(0, 32'h503, 1, 0, 32'h0,   0, 1, 0);            // pc[1:0] ignored
    add(0, 32'h404, 1, 0, 32'h0,   0, 0, 1);
    add(0, 32'h404, 0, 1, 32'h404, 1, BYP, BYP);
    add(0, 32'h404, 0, 0, 32'h0,   0, 1, 1);
    add(1, 32'h800, 0, 1, 32'h800, 1, 0, 0);            // flush beats update, no bypass
    add(0, 32'h800, 0, 0, 32'h0,   0, 0, 0);
    add(0, 32'h500, 1, 0, 32'h0,   0, 0, 1);
    add(0, 32'h404, 0, 0, 32'h0,   0, 0, 0);

    rst_ni = 1'b0; flush_i = 1'b0; update_en_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0;
    pc_i = 32'h400; fallback_taken_i = 1'b1;
    #3 check("in_reset_fb1", hit_o, taken_o, 1'b0, 1'b1);
    @(posedge clk_i); #1 check("in_reset_edge_fb1", hit_o, taken_o, 1'b0, 1'b1);
    fallback_taken_i = 1'b0;
    #1 check("in_reset_fb0", hit_o, taken_o, 1'b0, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      flush_i = vecs[i].flush; pc_i = vecs[i].pc; fallback_taken_i = vecs[i].fb;
      update_en_i = vecs[i].upd; update_pc_i = vecs[i].upc; update_taken_i = vecs[i].ut;
      e.id = i; e.eh = vecs[i].eh; e.et = vecs[i].et;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d", e.id), hit_o, taken_o, e.eh, e.et);
      end
    end

    // Allocate, then assert reset mid-cycle: outputs must drop without waiting for a clock.
    @(negedge clk_i);
    flush_i = 1'b0; update_en_i = 1'b1; update_pc_i = 32'h40C; update_taken_i = 1'b1;
    pc_i = 32'h40C; fallback_taken_i = 1'b0;
    @(negedge clk_i);
    update_en_i = 1'b0;
    #1 check("pre_reset_hit", hit_o, taken_o, 1'b1, 1'b1);
    rst_ni = 1'b0;
    #1 check("async_reset_fb0", hit_o, taken_o, 1'b0, 1'b0);
    fallback_taken_i = 1'b1;
    #1 check("async_reset_fb1", hit_o, taken_o, 1'b0, 1'b1);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    #1 check("post_reset_miss", hit_o, taken_o, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
